// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, status flag positions and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_NEG   = 4'b0011;
    localparam logic [3:0] OP_NOT   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_PASSX = 4'b0110;
    localparam logic [3:0] OP_PASSY = 4'b0111;
    localparam logic [3:0] OP_AND   = 4'b1000;
    localparam logic [3:0] OP_XOR   = 4'b1001;
    localparam logic [3:0] OP_ADC   = 4'b1010;
    localparam logic [3:0] OP_SHL   = 4'b1011;
    localparam logic [3:0] OP_ASR   = 4'b1100;
    localparam logic [3:0] OP_MUL   = 4'b1101;

    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_S = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Opcodes 1110 and 1111 are reserved and flagged as illegal.
    function automatic logic is_reserved(input logic [3:0] op);
        return (op == 4'b1110) || (op == 4'b1111);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the control FSM (master) and the sequential ALU (slave).
interface alu_seq_if #(parameter int WIDTH = 16) ();

    logic             start;
    logic [3:0]       fsel;
    logic [WIDTH-1:0] xybus;
    logic [WIDTH-1:0] y;
    logic             flag_we;
    logic [WIDTH-1:0] zbus;
    logic             cout;
    logic             zout;
    logic             vout;
    logic             sout;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, fsel, xybus, y, flag_we,
        input  zbus, cout, zout, vout, sout, busy, done, illegal
    );

    modport slave (
        input  start, fsel, xybus, y, flag_we,
        output zbus, cout, zout, vout, sout, busy, done, illegal
    );

endinterface

// File: rtl/seq_mult.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
module seq_mult #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] product_next
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    // The owner samples product_next on the step that makes the count reach WIDTH.
    assign product_next = acc + (mplier[0] ? mcand : '0);
    assign last         = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= product_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle datapath, C/Z/V/S status register and IDLE/MUL control FSM.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);

    localparam int MSB = WIDTH - 1;

    state_t             state;
    logic [WIDTH-1:0]   zbus_q;
    logic [3:0]         flags;
    logic               busy_q;
    logic               done_q;
    logic               illegal_q;
    logic               mul_we;

    logic [WIDTH-1:0]   a_op;
    logic [WIDTH-1:0]   b_op;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic               add_v;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic               res_v;
    logic               writes_flags;

    logic               accept;
    logic               mul_load;
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    assign accept   = (state == ST_IDLE) && bus.start;
    assign mul_load = accept && (bus.fsel == OP_MUL);

    seq_mult #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mult (
        .clk          (clk),
        .reset        (reset),
        .load         (mul_load),
        .step         (state == ST_MUL),
        .a            (bus.xybus),
        .b            (bus.y),
        .last         (mul_last),
        .product_next (mul_prod)
    );

    // One shared WIDTH+1 adder serves ADD, SUB, NEG and ADC.
    always_comb begin
        a_op = bus.xybus;
        b_op = bus.y;
        cin  = 1'b0;
        case (bus.fsel)
            OP_SUB:  begin b_op = ~bus.y; cin = 1'b1; end
            OP_NEG:  begin a_op = '0; b_op = ~bus.y; cin = 1'b1; end
            OP_ADC:  cin = flags[FLAG_C];
            default: ;
        endcase
    end

    assign sum   = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    assign add_v = (a_op[MSB] == b_op[MSB]) && (sum[MSB] != a_op[MSB]);

    always_comb begin
        res          = '0;
        res_c        = 1'b0;
        res_v        = 1'b0;
        writes_flags = 1'b1;
        case (bus.fsel)
            OP_ADD, OP_SUB, OP_ADC: begin
                res   = sum[MSB:0];
                res_c = sum[WIDTH];
                res_v = add_v;
            end
            OP_NEG: begin
                res   = sum[MSB:0];
                res_v = (bus.y == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_NOT:   res = ~bus.y;
            OP_OR:    res = bus.xybus | bus.y;
            OP_PASSX: res = bus.xybus;
            OP_PASSY: res = bus.y;
            OP_AND:   res = bus.xybus & bus.y;
            OP_XOR:   res = bus.xybus ^ bus.y;
            OP_SHL: begin
                res   = {bus.xybus[MSB-1:0], 1'b0};
                res_c = bus.xybus[MSB];
                res_v = bus.xybus[MSB] ^ bus.xybus[MSB-1];
            end
            OP_ASR: begin
                res   = {bus.xybus[MSB], bus.xybus[MSB:1]};
                res_c = bus.xybus[0];
            end
            default: writes_flags = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            zbus_q    <= '0;
            flags     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            mul_we    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.fsel == OP_MUL) begin
                            state  <= ST_MUL;
                            busy_q <= 1'b1;
                            mul_we <= bus.flag_we;
                        end else begin
                            done_q <= 1'b1;
                            if (is_reserved(bus.fsel)) begin
                                illegal_q <= 1'b1;
                                zbus_q    <= '0;
                            end else if (bus.fsel != OP_NOP) begin
                                zbus_q <= res;
                            end
                            if (bus.flag_we && writes_flags) begin
                                flags[FLAG_C] <= res_c;
                                flags[FLAG_Z] <= (res == '0);
                                flags[FLAG_V] <= res_v;
                                flags[FLAG_S] <= res[MSB];
                            end
                        end
                    end
                end
                ST_MUL: begin
                    // Starts arriving while busy are dropped, not queued.
                    if (mul_last) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        zbus_q <= mul_prod[MSB:0];
                        if (mul_we) begin
                            flags[FLAG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
                            flags[FLAG_Z] <= (mul_prod[MSB:0] == '0);
                            flags[FLAG_V] <= 1'b0;
                            flags[FLAG_S] <= mul_prod[MSB];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.zbus    = zbus_q;
    assign bus.cout    = flags[FLAG_C];
    assign bus.zout    = flags[FLAG_Z];
    assign bus.vout    = flags[FLAG_V];
    assign bus.sout    = flags[FLAG_S];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios followed by random ops against an arithmetic model.
module tb_alu_seq;

    localparam int WIDTH = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] m_z;
    logic        m_c, m_zf, m_v, m_s;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_output({tag, "_zbus"}, 32'(bus.zbus), 32'(m_z));
        check_output({tag, "_flags"}, 32'({bus.cout, bus.zout, bus.vout, bus.sout}),
                     32'({m_c, m_zf, m_v, m_s}));
    endtask

    function automatic logic ovf(input int s);
        return (s > 32767) || (s < -32768);
    endfunction

    // Reference: plain integer arithmetic on the operands, updating the expected zbus/flags.
    task automatic model_op(input logic [3:0] f, input logic [15:0] x, input logic [15:0] yv,
                            input logic we, output logic ill);
        int ux, uy, sx, sy, full;
        longint p;
        logic [15:0] r;
        logic c, v, wr;
        ux = int'(x);
        uy = int'(yv);
        sx = int'($signed(x));
        sy = int'($signed(yv));
        r = '0; c = 1'b0; v = 1'b0; wr = 1'b1; ill = 1'b0; p = 0;
        case (f)
            4'd0:  wr = 1'b0;
            4'd1:  begin full = ux + uy; r = 16'(full); c = (full > 65535); v = ovf(sx + sy); end
            4'd2:  begin r = 16'(ux - uy); c = (ux >= uy); v = ovf(sx - sy); end
            4'd3:  begin r = 16'(-uy); v = (yv == 16'h8000); end
            4'd4:  r = ~yv;
            4'd5:  r = x | yv;
            4'd6:  r = x;
            4'd7:  r = yv;
            4'd8:  r = x & yv;
            4'd9:  r = x ^ yv;
            4'd10: begin
                full = ux + uy + int'(m_c);
                r = 16'(full); c = (full > 65535); v = ovf(sx + sy + int'(m_c));
            end
            4'd11: begin r = 16'(ux * 2); c = x[15]; v = ovf(sx * 2); end
            4'd12: begin r = 16'(sx >>> 1); c = x[0]; end
            4'd13: begin p = longint'(ux) * longint'(uy); r = 16'(p); c = (p > 65535); end
            default: begin ill = 1'b1; wr = 1'b0; end
        endcase
        if (ill) begin
            m_z = '0;
        end else if (wr) begin
            m_z = r;
            if (we) begin
                m_c = c; m_zf = (r == 16'h0000); m_v = v; m_s = r[15];
            end
        end
    endtask

    task automatic apply_stimulus(input string tag, input logic [3:0] f, input logic [15:0] x,
                                  input logic [15:0] yv, input logic we);
        logic ill;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.fsel    = f;
        bus.xybus   = x;
        bus.y       = yv;
        bus.flag_we = we;
        model_op(f, x, yv, we, ill);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.fsel    = 4'($urandom);
        bus.xybus   = 16'($urandom);
        bus.y       = 16'($urandom);
        bus.flag_we = 1'($urandom);
        if (f == 4'd13) begin
            check_output({tag, "_mul_accept"}, 32'({bus.busy, bus.done}), 32'(2'b10));
            for (int k = 1; k <= WIDTH; k++) begin
                @(negedge clk);
                bus.start = 1'($urandom);
                bus.fsel  = 4'($urandom_range(1, 9));
                bus.xybus = 16'($urandom);
                bus.y     = 16'($urandom);
                @(posedge clk);
                #1;
                bus.start = 1'b0;
                if (k < WIDTH)
                    check_output({tag, "_mul_busy"}, 32'({bus.busy, bus.done}), 32'(2'b10));
            end
            check_output({tag, "_mul_done"}, 32'({bus.busy, bus.done, bus.illegal}), 32'(3'b010));
        end else begin
            check_output({tag, "_done"}, 32'({bus.busy, bus.done, bus.illegal}), {29'd0, 1'b0, 1'b1, ill});
        end
        check_state(tag);
        @(posedge clk);
        #1;
        check_output({tag, "_done_drop"}, 32'({bus.done, bus.illegal}), 32'(2'b00));
    endtask

    initial begin
        logic [3:0] f;
        logic       ill;
        int         saw_done;

        bus.start = 1'b0; bus.fsel = '0; bus.xybus = '0; bus.y = '0; bus.flag_we = 1'b0;
        m_z = '0; m_c = 0; m_zf = 0; m_v = 0; m_s = 0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_ctrl", 32'({bus.busy, bus.done, bus.illegal}), 32'(3'b000));
        check_state("reset");
        @(negedge clk);
        reset = 1'b1;

        apply_stimulus("add_ovf",   4'd1,  16'h7FFF, 16'h0001, 1'b1);
        apply_stimulus("add_carry", 4'd1,  16'hFFFF, 16'h0001, 1'b1);
        apply_stimulus("adc",       4'd10, 16'h0000, 16'h0000, 1'b1);
        apply_stimulus("add_c1",    4'd1,  16'hFFFF, 16'h0001, 1'b1);
        apply_stimulus("sub_nowe",  4'd2,  16'h0005, 16'h0007, 1'b0);
        apply_stimulus("sub_we",    4'd2,  16'h0005, 16'h0007, 1'b1);
        apply_stimulus("mul_big",   4'd13, 16'h0100, 16'h0100, 1'b1);

        // Reset in the middle of a multiply: everything clears and no done follows.
        @(negedge clk);
        bus.start = 1'b1; bus.fsel = 4'd13; bus.xybus = 16'h0003; bus.y = 16'h0005; bus.flag_we = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_z = '0; m_c = 0; m_zf = 0; m_v = 0; m_s = 0;
        check_output("mul_abort_ctrl", 32'({bus.busy, bus.done, bus.illegal}), 32'(3'b000));
        check_state("mul_abort");
        @(negedge clk);
        reset = 1'b1;
        saw_done = 0;
        repeat (WIDTH + 4) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done++;
        end
        check_output("mul_abort_no_done", 32'(saw_done), 32'd0);

        apply_stimulus("mul_small", 4'd13, 16'h0003, 16'h0005, 1'b1);
        apply_stimulus("reserved",  4'd14, 16'h1234, 16'h5678, 1'b1);
        apply_stimulus("neg_min",   4'd3,  16'h0000, 16'h8000, 1'b1);
        apply_stimulus("reserved2", 4'd15, 16'hFFFF, 16'hFFFF, 1'b1);
        apply_stimulus("shl_edge",  4'd11, 16'h4000, 16'h0000, 1'b1);
        apply_stimulus("asr_neg",   4'd12, 16'h8001, 16'h0000, 1'b1);
        apply_stimulus("nop",       4'd0,  16'hAAAA, 16'h5555, 1'b1);

        for (int i = 0; i < 60; i++) begin
            f = 4'($urandom_range(0, 15));
            apply_stimulus("rand", f, 16'($urandom), 16'($urandom), 1'($urandom));
        end
        ill = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised successor to the datapath's combinational ALU.
- Adds operand and result registers, a registered C/Z/V/S status register with write-enable, a carry-in op (ADC), shifts, AND/XOR, and an iterative shift-add multiply.
- Uses a start/busy/done handshake.
- Sits between the XY/Y operand buses and ZBUS in the CPU datapath; the control FSM issues one op at a time.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  op request; accepted only when busy=0.
- fsel  in  4  opcode, sampled on accept.
- xybus  in  WIDTH  operand X, sampled on accept.
- y  in  WIDTH  operand Y, sampled on accept.
- flag_we  in  1  sampled on accept; 1 = update status on completion.
- zbus  out  WIDTH  registered result.
- cout, zout, vout, sout  out  1 each  registered status flags C, Z, V, S.
- busy  out  1  multi-cycle op in progress.
- done  out  1  one-cycle pulse; zbus valid.
- illegal  out  1  one-cycle pulse with done for a reserved opcode.

Behaviour:
- Reset (reset=0 at an edge): zbus=0, C=Z=V=S=0, busy=0, done=0, illegal=0, FSM->IDLE. Reset aborts any multiply in progress; no done is produced for it.
- FSM states: IDLE, MUL.
  - IDLE: start=1 with a single-cycle opcode -> compute at that edge, stay IDLE.
  - IDLE: start=1 with MUL -> MUL.
  - MUL: counter reaches WIDTH -> IDLE.
- Accept: at edge N with start=1 and busy=0, the block latches fsel, xybus, y and flag_we. Later input changes have no effect. start while busy=1 is ignored (not queued).
- Single-cycle ops: zbus and flags update at edge N; done=1 for the cycle after edge N; latency 1.
- Opcodes (result; C; V):
  - 0000 NOP: zbus holds; flags unchanged; done pulses.
  - 0001 ADD: X+Y; C = carry out of bit WIDTH-1; V = carry into MSB xor carry out.
  - 0010 SUB: X+~Y+1; C = carry out (1 = no borrow); V = signed overflow.
  - 0011 NEG: ~Y+1; C=0; V=1 iff Y = 100..0.
  - 0100 NOT: ~Y; C=0; V=0.
  - 0101 OR: X|Y; C=0; V=0.
  - 0110 PASSX: X; C=0; V=0.
  - 0111 PASSY: Y; C=0; V=0.
  - 1000 AND: X&Y; C=0; V=0.
  - 1001 XOR: X^Y; C=0; V=0.
  - 1010 ADC: X+Y+C, where C is the current status flag; C and V as ADD.
  - 1011 SHL: X<<1; C = X[WIDTH-1]; V = X[WIDTH-1]^X[WIDTH-2].
  - 1100 ASR: X>>>1, sign-preserving; C = X[0]; V=0.
  - 1101 MUL: unsigned X*Y, low WIDTH bits; C=1 iff the upper WIDTH product bits are non-zero; V=0.
  - 1110, 1111 reserved: zbus=0; flags unchanged; done and illegal pulse together.
- Z and S for every flag-updating op: Z = (result==0), S = result[WIDTH-1].
- flag_we=0: zbus updates, all four flags hold.
- MUL timing:
  - Edge N: busy=1, counter=0, 2*WIDTH accumulator cleared.
  - Each subsequent edge performs one shift-add iteration.
  - Edge N+WIDTH: zbus and flags written, busy=0, done=1. Latency WIDTH cycles.
  - A new start is first accepted at edge N+WIDTH+1 (busy is 0 in the done cycle).
- zbus and flags hold between ops. done is never asserted two consecutive cycles for one op.
- Arithmetic is computed in WIDTH+1 bits; no X/Z leaks for any fsel value.

Decomposition:
- Shared package alu_pkg:
  - 4-bit opcode localparams (OP_NOP … OP_MUL).
  - Flag bit indices C=3, Z=2, V=1, S=0.
  - FSM state encoding.
- One natural sub-module: seq_mult (WIDTH-parametrised shift-add multiplier with load/step/done). alu_seq holds the combinational single-cycle datapath, the status register and the FSM.

Test Plan:
- WIDTH=16, ADD 7FFF+0001, flag_we=1 -> zbus=8000, C0 Z0 V1 S1, done one cycle after accept.
- ADD FFFF+0001, then ADC 0000+0000 -> first 0000 (C1 Z1 V0 S0), then 0001 (C0 Z0).
- SUB 0005-0007 with flag_we=0 after a prior ADD left C1 -> zbus=FFFE, flags unchanged. Repeat with flag_we=1 -> C0 S1 V0.
- MUL 0100*0100 -> busy 16 cycles, zbus=0000, C1 Z1; start pulses during busy ignored; done exactly at edge N+16.
- MUL 0003*0005, reset=0 at cycle 5 -> all outputs 0, no done. Then MUL 0003*0005 again after reset -> 000F, C0.
- fsel=1110 -> zbus=0000, done and illegal pulse together, flags unchanged. NEG 8000 -> 8000, V1 C0 S1.
